// File: rtl/rx_pkt_checker.sv
// rx_pkt_checker: receive-side packet endpoint on the MAC RX FIFO read port.
// It pulls packets with pkt_rx_ren and checks sop/eop framing, sequence
// continuity and the payload pattern. It keeps saturating statistics counters.
// Counter increments are captured in a one-cycle pending stage, so every
// counter moves on the cycle after the beat that caused it.
module rx_pkt_checker #(
  parameter int CNT_W   = 32,
  parameter int BYTE_W  = 48,
  parameter int SEQ_CHK = 1
) (
  input  logic              clk_156,
  input  logic              reset_156,
  input  logic              enable,
  input  logic              clear_cnt,
  input  logic              pkt_rx_avail,
  input  logic [63:0]       pkt_rx_data,
  input  logic              pkt_rx_sop,
  input  logic              pkt_rx_eop,
  input  logic [2:0]        pkt_rx_mod,
  input  logic              pkt_rx_err,
  input  logic              pkt_rx_val,
  output logic              pkt_rx_ren,
  output logic              busy,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic [BYTE_W-1:0] byte_cnt,
  output logic [CNT_W-1:0]  rx_err_cnt,
  output logic [CNT_W-1:0]  data_err_cnt,
  output logic [CNT_W-1:0]  seq_err_cnt,
  output logic [CNT_W-1:0]  frame_err_cnt,
  output logic [31:0]       last_seq
);

  // Byte count of one packet: a 32-bit beat count times 8.
  localparam int PB_W  = 35;
  localparam int SUM_W = ((BYTE_W > PB_W) ? BYTE_W : PB_W) + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_INPKT   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  // Saturating increment for packet/error counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    else    return v + CNT_W'(1'b1);
  endfunction

  // Saturating add of one packet's byte count into the byte counter.
  function automatic logic [BYTE_W-1:0] sat_add_bytes(input logic [BYTE_W-1:0] v,
                                                      input logic [PB_W-1:0]   a);
    logic [SUM_W-1:0] s;
    s = SUM_W'(v) + SUM_W'(a);
    if (s > SUM_W'({BYTE_W{1'b1}})) return {BYTE_W{1'b1}};
    else                            return s[BYTE_W-1:0];
  endfunction

  // Compare mask. On a partial eop beat only bytes 0..mod-1 are kept.
  // Byte 0 is the most significant lane.
  function automatic logic [63:0] lane_mask(input logic is_eop, input logic [2:0] nmod);
    logic [63:0] m;
    m = {64{1'b1}};
    if (is_eop && (nmod != 3'd0)) begin
      for (int k = 0; k < 8; k++) begin
        if (k >= int'(nmod)) m[63-8*k -: 8] = 8'h00;
      end
    end
    return m;
  endfunction

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_start;      // sop beat accepted: a packet (re)starts here
  logic                w_done;       // eop beat of a packet that gets counted
  logic                w_frame_ev;   // sop/eop protocol violation on this beat
  logic                w_in_beat;    // beat belongs to the packet being checked
  logic                r_active;

  logic [15:0]         r_beat_idx;   // index the next payload beat should carry
  logic [15:0]         w_beat_idx;
  logic [31:0]         r_nbeats;
  logic [31:0]         w_nbeats;
  logic                r_derr;
  logic                w_mis;
  logic                w_derr_pkt;
  logic [31:0]         r_last_seq;
  logic                r_seq_valid;
  logic                w_seq_ev;
  logic [3:0]          w_pad;
  logic [PB_W-1:0]     w_pkt_bytes;

  logic                r_upd_pkt;
  logic [PB_W-1:0]     r_upd_bytes;
  logic                r_upd_rxerr;
  logic                r_upd_derr;
  logic                r_upd_frame;
  logic                r_upd_seq;

  logic [CNT_W-1:0]    r_pkt_cnt;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [CNT_W-1:0]    r_rx_err_cnt;
  logic [CNT_W-1:0]    r_data_err_cnt;
  logic [CNT_W-1:0]    r_seq_err_cnt;
  logic [CNT_W-1:0]    r_frame_err_cnt;

  // Next-state logic, plus decoding of the beat currently on the bus.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_frame_ev  = 1'b0;
    w_in_beat   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && pkt_rx_avail) w_state_nxt = ST_READ;
        else                        w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        if (pkt_rx_val) begin
          if (pkt_rx_sop) begin
            w_start   = 1'b1;
            w_in_beat = 1'b1;
            if (pkt_rx_eop) begin
              w_done      = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt = ST_INPKT;
            end
          end else begin
            // A stray beat with no sop: flag it and drop data up to eop.
            // If this beat is already the eop, there is nothing left to drop.
            w_frame_ev = 1'b1;
            if (pkt_rx_eop) w_state_nxt = ST_IDLE;
            else            w_state_nxt = ST_DISCARD;
          end
        end else if (!enable) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_INPKT: begin
        if (pkt_rx_val) begin
          w_in_beat = 1'b1;
          if (pkt_rx_sop) begin
            // A second sop abandons the partial packet and restarts here.
            w_frame_ev = 1'b1;
            w_start    = 1'b1;
          end else begin
            w_start = 1'b0;
          end
          if (pkt_rx_eop) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_INPKT;
          end
        end else begin
          w_state_nxt = ST_INPKT;
        end
      end
      ST_DISCARD: begin
        if (pkt_rx_val && pkt_rx_eop) w_state_nxt = ST_IDLE;
        else                          w_state_nxt = ST_DISCARD;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Payload, sequence and length checks on the current beat.
  always_comb begin
    w_beat_idx  = w_start ? 16'd0 : r_beat_idx;
    w_nbeats    = w_start ? 32'd1 : (r_nbeats + 32'd1);
    w_mis       = ~w_start &
                  (|((pkt_rx_data ^ {48'd0, w_beat_idx}) & lane_mask(pkt_rx_eop, pkt_rx_mod)));
    w_derr_pkt  = (~w_start & r_derr) | w_mis;
    w_seq_ev    = w_start & r_seq_valid & (SEQ_CHK != 0) &
                  (pkt_rx_data[31:0] != (r_last_seq + 32'd1));
    if (pkt_rx_mod == 3'd0) w_pad = 4'd0;
    else                    w_pad = 4'd8 - {1'b0, pkt_rx_mod};
    w_pkt_bytes = {w_nbeats, 3'b000} - PB_W'(w_pad);
  end

  // State register. Read enable and busy are registered from the next state.
  always_ff @(posedge clk_156) begin
    if (reset_156) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_active <= (w_state_nxt != ST_IDLE);
    end
  end

  // Per-packet tracking: beat index, beat count and sticky payload error.
  always_ff @(posedge clk_156) begin
    if (reset_156) begin
      r_beat_idx <= 16'd0;
      r_nbeats   <= 32'd0;
      r_derr     <= 1'b0;
    end else if (w_in_beat) begin
      r_beat_idx <= w_beat_idx + 16'd1;
      r_nbeats   <= w_nbeats;
      r_derr     <= w_derr_pkt;
    end
  end

  // Sequence tracking. Every started packet reloads last_seq; clear resyncs.
  always_ff @(posedge clk_156) begin
    if (reset_156) begin
      r_last_seq  <= 32'd0;
      r_seq_valid <= 1'b0;
    end else begin
      if (w_start) begin
        r_last_seq  <= pkt_rx_data[31:0];
        r_seq_valid <= 1'b1;
      end
      if (clear_cnt) r_seq_valid <= 1'b0;
    end
  end

  // Pending-update stage: capture this beat's counter events for next cycle.
  always_ff @(posedge clk_156) begin
    if (reset_156) begin
      r_upd_pkt   <= 1'b0;
      r_upd_bytes <= {PB_W{1'b0}};
      r_upd_rxerr <= 1'b0;
      r_upd_derr  <= 1'b0;
      r_upd_frame <= 1'b0;
      r_upd_seq   <= 1'b0;
    end else begin
      r_upd_pkt   <= w_done;
      r_upd_bytes <= w_pkt_bytes;
      r_upd_rxerr <= w_done & pkt_rx_err;
      r_upd_derr  <= w_done & w_derr_pkt;
      r_upd_frame <= w_frame_ev;
      r_upd_seq   <= w_seq_ev;
    end
  end

  // Statistics counters. They saturate, and a coincident clear beats an update.
  always_ff @(posedge clk_156) begin
    if (reset_156 || clear_cnt) begin
      r_pkt_cnt       <= {CNT_W{1'b0}};
      r_byte_cnt      <= {BYTE_W{1'b0}};
      r_rx_err_cnt    <= {CNT_W{1'b0}};
      r_data_err_cnt  <= {CNT_W{1'b0}};
      r_seq_err_cnt   <= {CNT_W{1'b0}};
      r_frame_err_cnt <= {CNT_W{1'b0}};
    end else begin
      if (r_upd_pkt) begin
        r_pkt_cnt  <= sat_inc(r_pkt_cnt);
        r_byte_cnt <= sat_add_bytes(r_byte_cnt, r_upd_bytes);
      end
      if (r_upd_rxerr) r_rx_err_cnt    <= sat_inc(r_rx_err_cnt);
      if (r_upd_derr)  r_data_err_cnt  <= sat_inc(r_data_err_cnt);
      if (r_upd_seq)   r_seq_err_cnt   <= sat_inc(r_seq_err_cnt);
      if (r_upd_frame) r_frame_err_cnt <= sat_inc(r_frame_err_cnt);
    end
  end

  assign pkt_rx_ren    = r_active;
  assign busy          = r_active;
  assign pkt_cnt       = r_pkt_cnt;
  assign byte_cnt      = r_byte_cnt;
  assign rx_err_cnt    = r_rx_err_cnt;
  assign data_err_cnt  = r_data_err_cnt;
  assign seq_err_cnt   = r_seq_err_cnt;
  assign frame_err_cnt = r_frame_err_cnt;
  assign last_seq      = r_last_seq;

endmodule

// File: tb/tb_rx_pkt_checker.sv
// Self-checking bench for rx_pkt_checker.
// A packet-level reference model tracks the expected counters from the
// framing, sequence, payload and length rules. A second instance with narrow
// counters shares the same stimulus and exercises saturation.
module tb_rx_pkt_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        clear_cnt;
  logic        avail;
  logic [63:0] data;
  logic        sop, eop, err, val;
  logic [2:0]  mod;

  logic        pkt_rx_ren, busy;
  logic [31:0] pkt_cnt, rx_err_cnt, data_err_cnt, seq_err_cnt, frame_err_cnt, last_seq;
  logic [47:0] byte_cnt;

  logic        s_ren, s_busy;
  logic [2:0]  s_pkt_cnt, s_rx_err_cnt, s_data_err_cnt, s_seq_err_cnt, s_frame_err_cnt;
  logic [7:0]  s_byte_cnt;
  logic [31:0] s_last_seq;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  longint      e_pkt, e_byte, e_rx, e_data, e_seq, e_frame;
  logic [31:0] e_last;
  bit          e_seq_valid, e_in_pkt;

  always #5 clk = ~clk;

  rx_pkt_checker #(.CNT_W(32), .BYTE_W(48), .SEQ_CHK(1)) dut (
    .clk_156(clk), .reset_156(rst), .enable(enable), .clear_cnt(clear_cnt),
    .pkt_rx_avail(avail), .pkt_rx_data(data), .pkt_rx_sop(sop), .pkt_rx_eop(eop),
    .pkt_rx_mod(mod), .pkt_rx_err(err), .pkt_rx_val(val),
    .pkt_rx_ren(pkt_rx_ren), .busy(busy), .pkt_cnt(pkt_cnt), .byte_cnt(byte_cnt),
    .rx_err_cnt(rx_err_cnt), .data_err_cnt(data_err_cnt), .seq_err_cnt(seq_err_cnt),
    .frame_err_cnt(frame_err_cnt), .last_seq(last_seq)
  );

  rx_pkt_checker #(.CNT_W(3), .BYTE_W(8), .SEQ_CHK(1)) dut_small (
    .clk_156(clk), .reset_156(rst), .enable(enable), .clear_cnt(clear_cnt),
    .pkt_rx_avail(avail), .pkt_rx_data(data), .pkt_rx_sop(sop), .pkt_rx_eop(eop),
    .pkt_rx_mod(mod), .pkt_rx_err(err), .pkt_rx_val(val),
    .pkt_rx_ren(s_ren), .busy(s_busy), .pkt_cnt(s_pkt_cnt), .byte_cnt(s_byte_cnt),
    .rx_err_cnt(s_rx_err_cnt), .data_err_cnt(s_data_err_cnt), .seq_err_cnt(s_seq_err_cnt),
    .frame_err_cnt(s_frame_err_cnt), .last_seq(s_last_seq)
  );

  // Hard stop if the run stalls somewhere unexpected.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic model_zero();
    e_pkt = 0; e_byte = 0; e_rx = 0; e_data = 0; e_seq = 0; e_frame = 0;
    e_seq_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear_cnt = 1'b1;
    @(negedge clk);
    clear_cnt = 1'b0;
    model_zero();
  endtask

  // Present one beat once the DUT is reading. The wait is bounded.
  task automatic drive_beat(input logic [63:0] d, input logic s, input logic e,
                            input logic [2:0] m, input logic er);
    int t = 0;
    while (pkt_rx_ren !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (pkt_rx_ren !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_ren_timeout: pkt_rx_ren=%b, required 1 within 200 cycles", pkt_rx_ren);
    end else begin
      data = d; sop = s; eop = e; mod = m; err = er; val = 1'b1;
      @(negedge clk);
      val = 1'b0; sop = 1'b0; eop = 1'b0; err = 1'b0;
    end
  endtask

  // Send one packet of n beats. cb/cl select a corrupted byte (beat, lane).
  // cb < 1 means no corruption. trunc > 0 sends only that many beats with no eop.
  // en_drop >= 0 deasserts enable before that beat.
  task automatic send_pkt(input int n, input logic [31:0] seq, input logic [2:0] m,
                          input logic er, input int cb, input int cl, input int trunc,
                          input int gapmax, input int en_drop);
    int nb;
    nb = (trunc > 0) ? trunc : n;
    for (int b = 0; b < nb; b++) begin
      logic [63:0] d;
      logic [15:0] bi;
      logic        last;
      bi   = 16'(b);
      last = (trunc == 0) && (b == n - 1);
      if (b == 0) d = {$urandom(), seq};
      else        d = {48'd0, bi};
      if (b == cb && b >= 1) d[63-8*cl -: 8] = d[63-8*cl -: 8] ^ 8'hA5;
      if (gapmax > 0) repeat ($urandom_range(gapmax, 0)) @(negedge clk);
      if (b == en_drop) enable = 1'b0;
      drive_beat(d, (b == 0), last, last ? m : 3'($urandom_range(7, 0)), er && last);
    end
    // Model the effect of this packet at packet level.
    if (e_in_pkt) e_frame++;
    if (e_seq_valid && seq != e_last + 32'd1) e_seq++;
    e_last      = seq;
    e_seq_valid = 1'b1;
    if (trunc > 0) begin
      e_in_pkt = 1'b1;
    end else begin
      e_in_pkt = 1'b0;
      e_pkt++;
      e_byte += 8 * n - ((m == 3'd0) ? 0 : (8 - int'(m)));
      if (er) e_rx++;
      if (cb >= 1 && cb < n && (cb != n - 1 || m == 3'd0 || cl < int'(m))) e_data++;
    end
  endtask

  // Beats with no sop, the last one carrying eop. Use only when no packet is open.
  task automatic send_junk(input int n);
    for (int b = 0; b < n; b++) begin
      drive_beat({$urandom(), $urandom()}, 1'b0, (b == n - 1), 3'd0, 1'b0);
    end
    e_frame++;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; clear_cnt = 1'b0; avail = 1'b0;
    data = 64'd0; sop = 1'b0; eop = 1'b0; mod = 3'd0; err = 1'b0; val = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (pkt_rx_ren !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ren_busy: ren=%b busy=%b, required 0 0", pkt_rx_ren, busy);
    end
    n_checks++;
    if (pkt_cnt !== 32'd0 || byte_cnt !== 48'd0) begin
      n_fail++; $display("FAIL reset_pkt_byte: pkt=%0d bytes=%0d, required 0 0", pkt_cnt, byte_cnt);
    end
    n_checks++;
    if ({rx_err_cnt, data_err_cnt, seq_err_cnt, frame_err_cnt} !== 128'd0 || last_seq !== 32'd0) begin
      n_fail++; $display("FAIL reset_err_seq: rx=%0d data=%0d seq=%0d frame=%0d last=%0d, required all 0",
                         rx_err_cnt, data_err_cnt, seq_err_cnt, frame_err_cnt, last_seq);
    end
    n_checks++;
    if (s_ren !== 1'b0 || s_busy !== 1'b0 || s_pkt_cnt !== 3'd0 || s_byte_cnt !== 8'd0) begin
      n_fail++; $display("FAIL reset_small: ren=%b busy=%b pkt=%0d bytes=%0d, required 0", s_ren, s_busy, s_pkt_cnt, s_byte_cnt);
    end
    rst = 1'b0;
    model_zero();
    e_last = 32'd0; e_in_pkt = 1'b0;
    enable = 1'b1; avail = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_clear();
    send_pkt(8, 32'd0, 3'd4, 1'b0, -1, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL basic_pkt_cnt: got %0d, required 1", pkt_cnt); end
    n_checks++;
    if (byte_cnt !== 48'd60) begin n_fail++; $display("FAIL basic_byte_cnt: got %0d, required 60", byte_cnt); end
    n_checks++;
    if ({rx_err_cnt, data_err_cnt, seq_err_cnt, frame_err_cnt} !== 128'd0) begin
      n_fail++; $display("FAIL basic_errors: rx=%0d data=%0d seq=%0d frame=%0d, required 0",
                         rx_err_cnt, data_err_cnt, seq_err_cnt, frame_err_cnt);
    end
    n_checks++;
    if (last_seq !== 32'd0) begin n_fail++; $display("FAIL basic_last_seq: got %0d, required 0", last_seq); end
  endtask

  task automatic test_sequence();
    do_clear();
    send_pkt(2, 32'd5, 3'd0, 1'b0, -1, 0, 0, 0, -1);
    send_pkt(2, 32'd6, 3'd0, 1'b0, -1, 0, 0, 0, -1);
    send_pkt(2, 32'd8, 3'd0, 1'b0, -1, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (seq_err_cnt !== 32'd1) begin n_fail++; $display("FAIL seq_gap_cnt: got %0d, required 1", seq_err_cnt); end
    n_checks++;
    if (last_seq !== 32'd8) begin n_fail++; $display("FAIL seq_last: got %0d, required 8", last_seq); end
    do_clear();
    send_pkt(2, 32'd20, 3'd0, 1'b0, -1, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (seq_err_cnt !== 32'd0 || pkt_cnt !== 32'd1 || last_seq !== 32'd20) begin
      n_fail++; $display("FAIL seq_resync: seq_err=%0d pkt=%0d last=%0d, required 0 1 20",
                         seq_err_cnt, pkt_cnt, last_seq);
    end
  endtask

  task automatic test_payload();
    do_clear();
    send_pkt(6, 32'd30, 3'd0, 1'b0, 3, 2, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_err_cnt !== 32'd1 || pkt_cnt !== 32'd1) begin
      n_fail++; $display("FAIL payload_mid_corrupt: data_err=%0d pkt=%0d, required 1 1", data_err_cnt, pkt_cnt);
    end
    send_pkt(4, 32'd31, 3'd3, 1'b0, 3, 5, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_err_cnt !== 32'd1 || pkt_cnt !== 32'd2 || byte_cnt !== 48'd75) begin
      n_fail++; $display("FAIL payload_masked_lane: data_err=%0d pkt=%0d bytes=%0d, required 1 2 75",
                         data_err_cnt, pkt_cnt, byte_cnt);
    end
    send_pkt(4, 32'd32, 3'd3, 1'b0, 3, 1, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (data_err_cnt !== 32'd2) begin
      n_fail++; $display("FAIL payload_checked_lane: data_err=%0d, required 2", data_err_cnt);
    end
  endtask

  task automatic test_frame();
    do_clear();
    send_pkt(5, 32'd40, 3'd0, 1'b0, -1, 0, 3, 0, -1);
    send_pkt(4, 32'd41, 3'd2, 1'b0, 2, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (frame_err_cnt !== 32'd1 || pkt_cnt !== 32'd1 || byte_cnt !== 48'd26 ||
        data_err_cnt !== 32'd1 || seq_err_cnt !== 32'd0) begin
      n_fail++; $display("FAIL frame_mid_sop: frame=%0d pkt=%0d bytes=%0d data=%0d seq=%0d, required 1 1 26 1 0",
                         frame_err_cnt, pkt_cnt, byte_cnt, data_err_cnt, seq_err_cnt);
    end
    send_junk(3);
    repeat (3) @(negedge clk);
    n_checks++;
    if (frame_err_cnt !== 32'd2 || pkt_cnt !== 32'd1) begin
      n_fail++; $display("FAIL frame_discard: frame=%0d pkt=%0d, required 2 1", frame_err_cnt, pkt_cnt);
    end
    send_pkt(2, 32'd42, 3'd0, 1'b0, -1, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (pkt_cnt !== 32'd2 || seq_err_cnt !== 32'd0) begin
      n_fail++; $display("FAIL frame_after_discard: pkt=%0d seq=%0d, required 2 0", pkt_cnt, seq_err_cnt);
    end
  endtask

  task automatic test_rx_err();
    do_clear();
    send_pkt(3, 32'd50, 3'd0, 1'b1, -1, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (rx_err_cnt !== 32'd1 || pkt_cnt !== 32'd1) begin
      n_fail++; $display("FAIL rx_err_flag: rx_err=%0d pkt=%0d, required 1 1", rx_err_cnt, pkt_cnt);
    end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 11; i++) send_pkt(3, 32'(100 + i), 3'd0, 1'b0, -1, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (s_pkt_cnt !== 3'd7 || s_byte_cnt !== 8'd255) begin
      n_fail++; $display("FAIL sat_small: pkt=%0d bytes=%0d, required 7 255", s_pkt_cnt, s_byte_cnt);
    end
    n_checks++;
    if (pkt_cnt !== 32'd11 || byte_cnt !== 48'd264) begin
      n_fail++; $display("FAIL sat_wide: pkt=%0d bytes=%0d, required 11 264", pkt_cnt, byte_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    do_clear();
    send_pkt(10, 32'd60, 3'd0, 1'b0, -1, 0, 4, 0, -1);
    while (pkt_rx_ren !== 1'b1 && t < 200) begin @(negedge clk); t++; end
    data = {48'd0, 16'd4}; sop = 1'b0; eop = 1'b0; mod = 3'd0; val = 1'b1; rst = 1'b1;
    @(negedge clk);
    val = 1'b0;
    n_checks++;
    if (pkt_rx_ren !== 1'b0 || busy !== 1'b0 || pkt_cnt !== 32'd0 || last_seq !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_pkt: ren=%b busy=%b pkt=%0d last=%0d, required 0 0 0 0",
                         pkt_rx_ren, busy, pkt_cnt, last_seq);
    end
    rst = 1'b0;
    model_zero();
    e_last = 32'd0; e_in_pkt = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_enable_low();
    do_clear();
    send_pkt(6, 32'd70, 3'd0, 1'b0, -1, 0, 0, 0, 2);
    n_checks++;
    if (pkt_rx_ren !== 1'b0) begin
      n_fail++; $display("FAIL enable_low_ren_after_eop: ren=%b, required 0", pkt_rx_ren);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (pkt_rx_ren !== 1'b0 || pkt_cnt !== 32'd1 || byte_cnt !== 48'd48) begin
      n_fail++; $display("FAIL enable_low_complete: ren=%b pkt=%0d bytes=%0d, required 0 1 48",
                         pkt_rx_ren, pkt_cnt, byte_cnt);
    end
    enable = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 0; i < 5; i++) send_pkt(1 + i, 32'(200 + i), 3'(i), 1'b0, -1, 0, 0, 0, -1);
    repeat (3) @(negedge clk);
    n_checks++;
    if (pkt_cnt !== 32'(e_pkt) || byte_cnt !== 48'(e_byte) || seq_err_cnt !== 32'(e_seq)) begin
      n_fail++; $display("FAIL back_to_back: pkt=%0d bytes=%0d seq=%0d, required %0d %0d %0d",
                         pkt_cnt, byte_cnt, seq_err_cnt, e_pkt, e_byte, e_seq);
    end
  endtask

  task automatic test_random();
    do_clear();
    for (int it = 0; it < 40; it++) begin
      int          n, cb, cl;
      logic [31:0] seq;
      logic [2:0]  m;
      logic        er;
      if (!e_in_pkt && $urandom_range(7, 0) == 0) send_junk($urandom_range(4, 2));
      if ($urandom_range(7, 0) == 0) begin
        n = $urandom_range(6, 2);
        send_pkt(n, e_last + 32'd1, 3'd0, 1'b0, -1, 0, $urandom_range(n - 1, 1), 2, -1);
      end
      n   = $urandom_range(10, 1);
      seq = ($urandom_range(4, 0) == 0) ? 32'($urandom()) : e_last + 32'd1;
      m   = 3'($urandom_range(7, 0));
      er  = ($urandom_range(7, 0) == 0);
      cb  = ($urandom_range(2, 0) == 0 && n > 1) ? $urandom_range(n - 1, 1) : -1;
      cl  = $urandom_range(7, 0);
      send_pkt(n, seq, m, er, cb, cl, 0, 2, -1);
      repeat (3) @(negedge clk);
      n_checks++;
      if (pkt_cnt !== 32'(e_pkt) || byte_cnt !== 48'(e_byte)) begin
        n_fail++; $display("FAIL rand_pkt_bytes[%0d]: pkt=%0d bytes=%0d, required %0d %0d",
                           it, pkt_cnt, byte_cnt, e_pkt, e_byte);
      end
      n_checks++;
      if (rx_err_cnt !== 32'(e_rx) || data_err_cnt !== 32'(e_data)) begin
        n_fail++; $display("FAIL rand_rx_data[%0d]: rx=%0d data=%0d, required %0d %0d",
                           it, rx_err_cnt, data_err_cnt, e_rx, e_data);
      end
      n_checks++;
      if (seq_err_cnt !== 32'(e_seq) || frame_err_cnt !== 32'(e_frame) || last_seq !== e_last) begin
        n_fail++; $display("FAIL rand_seq_frame[%0d]: seq=%0d frame=%0d last=%0d, required %0d %0d %0d",
                           it, seq_err_cnt, frame_err_cnt, last_seq, e_seq, e_frame, e_last);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sequence();
    test_payload();
    test_frame();
    test_rx_err();
    test_saturation();
    test_reset_mid();
    test_enable_low();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
